// File: rtl/key_space_dispatcher.sv
// key_space_dispatcher: splits the key space into fixed-size chunks, hands them round-robin
// to NUM_CORES cracker cores, and reports the first hit or exhaustion. Optional stats: `KSD_STATS_EN.
module key_space_dispatcher #(
  parameter int unsigned      NUM_CORES  = 4,
  parameter int unsigned      KEY_W      = 24,
  parameter logic [KEY_W-1:0] KEY_MAX    = KEY_W'(24'h3FFFFF),
  parameter int unsigned      CHUNK_LOG2 = 12,
  localparam int unsigned     IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int unsigned     CNT_W      = KEY_W - CHUNK_LOG2 + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_ready,
  output logic [NUM_CORES-1:0]       core_launch,
  output logic [KEY_W-1:0]           chunk_first,
  output logic [KEY_W-1:0]           chunk_last,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_hit,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       abort,
  output logic [KEY_W-1:0]           key,
  output logic                       found,
  output logic                       not_found,
`ifdef KSD_STATS_EN
  output logic [CNT_W-1:0]           chunks_issued,
  output logic [IDX_W-1:0]           hit_core,
`endif
  output logic                       busy
);

  localparam int unsigned      XW         = KEY_W + 1;
  localparam logic [XW-1:0]    KEY_MAX_X  = {1'b0, KEY_MAX};
  localparam logic [XW-1:0]    CHUNK_SPAN = XW'((64'd1 << CHUNK_LOG2) - 64'd1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [XW-1:0]        next_key_q, next_key_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] inflight_q, inflight_d;
  logic [NUM_CORES-1:0] core_launch_q, core_launch_d;
  logic [KEY_W-1:0]     chunk_first_q, chunk_first_d;
  logic [KEY_W-1:0]     chunk_last_q, chunk_last_d;
  logic                 abort_q, abort_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic                 found_q, found_d;
  logic                 not_found_q, not_found_d;
  logic                 busy_q, busy_d;
`ifdef KSD_STATS_EN
  logic [CNT_W-1:0]     chunks_q, chunks_d;
  logic [IDX_W-1:0]     hit_core_q, hit_core_d;
`endif

  logic                 start_ok;
  logic                 in_search;
  logic [NUM_CORES-1:0] base_inflight;
  logic [XW-1:0]        base_next;
  logic [NUM_CORES-1:0] done_vld;
  logic [NUM_CORES-1:0] hit_vec;
  logic [NUM_CORES-1:0] eligible;
  logic                 launch_en;
  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic [KEY_W-1:0]     hit_key;
  logic [XW-1:0]        span_end;
  logic [XW-1:0]        last_x;
  int unsigned          cand;

  // A start seen in IDLE/DONE arbitrates on the same edge with freshly cleared search state.
  always_comb begin
    start_ok      = start && (state_q == S_IDLE || state_q == S_DONE);
    in_search     = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    base_inflight = start_ok ? '0 : inflight_q;
    base_next     = start_ok ? '0 : next_key_q;
    done_vld      = in_search ? (core_done & inflight_q) : '0;
    hit_vec       = done_vld & core_hit;
    eligible      = core_ready & ~base_inflight;
    span_end      = base_next + CHUNK_SPAN;
    last_x        = (span_end > KEY_MAX_X) ? KEY_MAX_X : span_end;
  end

  // Round-robin grant starting at rr_ptr; lowest-index hit priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!grant_vld && eligible[IDX_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    hit_any = 1'b0;
    hit_idx = '0;
    hit_key = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!hit_any && hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
        hit_key = core_key[i*KEY_W +: KEY_W];
      end
    end
    launch_en = ((state_q == S_DISPATCH) || start_ok) && !hit_any && (base_next <= KEY_MAX_X);
  end

  always_comb begin
    state_d       = state_q;
    next_key_d    = next_key_q;
    rr_ptr_d      = rr_ptr_q;
    inflight_d    = inflight_q & ~done_vld;
    core_launch_d = '0;
    chunk_first_d = chunk_first_q;
    chunk_last_d  = chunk_last_q;
    abort_d       = 1'b0;
    key_d         = key_q;
    found_d       = found_q;
    not_found_d   = not_found_q;
`ifdef KSD_STATS_EN
    chunks_d      = chunks_q;
    hit_core_d    = hit_core_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d     = S_DISPATCH;
          found_d     = 1'b0;
          not_found_d = 1'b0;
          next_key_d  = '0;
          inflight_d  = '0;
`ifdef KSD_STATS_EN
          chunks_d    = '0;
`endif
        end
      end
      S_DISPATCH: state_d = S_DISPATCH;
      S_DRAIN: begin
        if (inflight_d == '0) begin
          state_d     = S_DONE;
          not_found_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch_en && grant_vld) begin
      core_launch_d[grant_idx] = 1'b1;
      inflight_d[grant_idx]    = 1'b1;
      chunk_first_d            = base_next[KEY_W-1:0];
      chunk_last_d             = last_x[KEY_W-1:0];
      next_key_d               = last_x + XW'(1);
      rr_ptr_d                 = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
`ifdef KSD_STATS_EN
      chunks_d                 = chunks_d + CNT_W'(1);
`endif
      if (next_key_d > KEY_MAX_X) state_d = S_DRAIN;
    end

    // A hit overrides exhaustion and discards whatever is still in flight.
    if (hit_any) begin
      state_d     = S_DONE;
      key_d       = hit_key;
      found_d     = 1'b1;
      not_found_d = 1'b0;
      abort_d     = 1'b1;
      inflight_d  = '0;
`ifdef KSD_STATS_EN
      hit_core_d  = hit_idx;
`endif
    end

    busy_d = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      next_key_q    <= '0;
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      core_launch_q <= '0;
      chunk_first_q <= '0;
      chunk_last_q  <= '0;
      abort_q       <= 1'b0;
      key_q         <= '0;
      found_q       <= 1'b0;
      not_found_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef KSD_STATS_EN
      chunks_q      <= '0;
      hit_core_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      next_key_q    <= next_key_d;
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      core_launch_q <= core_launch_d;
      chunk_first_q <= chunk_first_d;
      chunk_last_q  <= chunk_last_d;
      abort_q       <= abort_d;
      key_q         <= key_d;
      found_q       <= found_d;
      not_found_q   <= not_found_d;
      busy_q        <= busy_d;
`ifdef KSD_STATS_EN
      chunks_q      <= chunks_d;
      hit_core_q    <= hit_core_d;
`endif
    end
  end

  assign core_launch = core_launch_q;
  assign chunk_first = chunk_first_q;
  assign chunk_last  = chunk_last_q;
  assign abort       = abort_q;
  assign key         = key_q;
  assign found       = found_q;
  assign not_found   = not_found_q;
  assign busy        = busy_q;
`ifdef KSD_STATS_EN
  assign chunks_issued = chunks_q;
  assign hit_core      = hit_core_q;
`endif

endmodule

// File: tb/tb_key_space_dispatcher.sv
// Directed bench for key_space_dispatcher: a 6-bit space ending at 2^6-1 (carry case) and an
// 8-bit space ending at 40 (truncated last chunk) driven side by side with shared core inputs.
module tb_key_space_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  core_ready;
  logic [3:0]  core_done;
  logic [3:0]  core_hit;
  logic [23:0] key_a;
  logic [31:0] key_b;

  logic [3:0]  launch_a, launch_b;
  logic [5:0]  first_a, last_a, keyo_a;
  logic [7:0]  first_b, last_b, keyo_b;
  logic        abort_a, found_a, nf_a, busy_a;
  logic        abort_b, found_b, nf_b, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_space_dispatcher #(.NUM_CORES(4), .KEY_W(6), .KEY_MAX(6'd63), .CHUNK_LOG2(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .core_ready(core_ready),
    .core_launch(launch_a), .chunk_first(first_a), .chunk_last(last_a),
    .core_done(core_done), .core_hit(core_hit), .core_key(key_a),
    .abort(abort_a), .key(keyo_a), .found(found_a), .not_found(nf_a), .busy(busy_a)
  );

  key_space_dispatcher #(.NUM_CORES(4), .KEY_W(8), .KEY_MAX(8'd40), .CHUNK_LOG2(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .core_ready(core_ready),
    .core_launch(launch_b), .chunk_first(first_b), .chunk_last(last_b),
    .core_done(core_done), .core_hit(core_hit), .core_key(key_b),
    .abort(abort_b), .key(keyo_b), .found(found_b), .not_found(nf_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".launch"}, 32'(launch_a), 0);
    chk({tag, ".first"}, 32'(first_a), 0);
    chk({tag, ".last"}, 32'(last_a), 0);
    chk({tag, ".abort"}, 32'(abort_a), 0);
    chk({tag, ".key"}, 32'(keyo_a), 0);
    chk({tag, ".found"}, 32'(found_a), 0);
    chk({tag, ".not_found"}, 32'(nf_a), 0);
    chk({tag, ".busy"}, 32'(busy_a), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    core_ready = 4'h0;
    core_done  = 4'h0;
    core_hit   = 4'h0;
    key_a      = '0;
    key_b      = '0;
    do_reset();
    chk_reset_a("rst");
    chk("rst.b_busy", 32'(busy_b), 0);

    // Full sweep with no hits; dut_b truncates its third chunk and drains early.
    core_ready = 4'hF;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1.l0", 32'(launch_a), 1);
    chk("t1.f0", 32'(first_a), 0);
    chk("t1.e0", 32'(last_a), 15);
    chk("t1.busy", 32'(busy_a), 1);
    chk("t1.b_l0", 32'(launch_b), 1);
    step();
    chk("t1.l1", 32'(launch_a), 2);
    chk("t1.f1", 32'(first_a), 16);
    chk("t1.e1", 32'(last_a), 31);
    step();
    chk("t1.l2", 32'(launch_a), 4);
    chk("t1.f2", 32'(first_a), 32);
    chk("t1.e2", 32'(last_a), 47);
    chk("t3.b_l2", 32'(launch_b), 4);
    chk("t3.b_f2", 32'(first_b), 32);
    chk("t3.b_e2", 32'(last_b), 40);
    step();
    chk("t1.l3", 32'(launch_a), 8);
    chk("t1.f3", 32'(first_a), 48);
    chk("t1.e3", 32'(last_a), 63);
    chk("t3.b_nolaunch", 32'(launch_b), 0);
    chk("t3.b_busy", 32'(busy_b), 1);
    step();
    chk("t1.drain_nolaunch", 32'(launch_a), 0);
    chk("t1.drain_busy", 32'(busy_a), 1);
    chk("t1.drain_nf", 32'(nf_a), 0);
    core_done = 4'hF;
    step();
    core_done = 4'h0;
    chk("t1.nf", 32'(nf_a), 1);
    chk("t1.found", 32'(found_a), 0);
    chk("t1.idle", 32'(busy_a), 0);
    chk("t3.b_nf", 32'(nf_b), 1);

    // Restart from DONE; core 2 reports key 37.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2.l0", 32'(launch_a), 1);
    chk("t2.nf_clr", 32'(nf_a), 0);
    step();
    chk("t2.l1", 32'(launch_a), 2);
    step();
    chk("t2.l2", 32'(launch_a), 4);
    core_done = 4'b0100;
    core_hit  = 4'b0100;
    key_a[12 +: 6] = 6'd37;
    step();
    core_done = 4'h0;
    core_hit  = 4'h0;
    chk("t2.found", 32'(found_a), 1);
    chk("t2.key", 32'(keyo_a), 37);
    chk("t2.abort", 32'(abort_a), 1);
    chk("t2.nolaunch", 32'(launch_a), 0);
    chk("t2.busy", 32'(busy_a), 0);
    step();
    chk("t2.abort_pulse", 32'(abort_a), 0);
    chk("t2.found_hold", 32'(found_a), 1);
    chk("t2.nolaunch2", 32'(launch_a), 0);

    // Simultaneous hits on cores 1 and 3 while every core finishes: lowest index, found wins.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("t4.l3", 32'(launch_a), 8);
    core_done = 4'hF;
    core_hit  = 4'b1010;
    key_a[6 +: 6]  = 6'd20;
    key_a[18 +: 6] = 6'd55;
    step();
    core_done = 4'h0;
    core_hit  = 4'h0;
    chk("t4.found", 32'(found_a), 1);
    chk("t4.key", 32'(keyo_a), 20);
    chk("t4.nf", 32'(nf_a), 0);
    chk("t4.abort", 32'(abort_a), 1);

    // Only core 2 ever ready; stray done from idle core 0 is ignored; no same-cycle relaunch.
    do_reset();
    core_ready = 4'b0100;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5.l0", 32'(launch_a), 4);
    chk("t5.f0", 32'(first_a), 0);
    chk("t5.e0", 32'(last_a), 15);
    core_ready = 4'h0;
    core_done  = 4'b0001;
    core_hit   = 4'b0001;
    key_a[0 +: 6] = 6'd9;
    step();
    chk("t5.stray_found", 32'(found_a), 0);
    chk("t5.stray_busy", 32'(busy_a), 1);
    chk("t5.wait", 32'(launch_a), 0);
    core_hit   = 4'h0;
    core_done  = 4'b0100;
    core_ready = 4'b0100;
    step();
    core_done = 4'h0;
    chk("t5.no_relaunch", 32'(launch_a), 0);
    step();
    chk("t5.l1", 32'(launch_a), 4);
    chk("t5.f1", 32'(first_a), 16);
    chk("t5.e1", 32'(last_a), 31);

    // Reset in the middle of DISPATCH, then a fresh search.
    core_ready = 4'hF;
    reset = 1'b1;
    step();
    chk_reset_a("t6.rst");
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6.l0", 32'(launch_a), 1);
    chk("t6.f0", 32'(first_a), 0);
    chk("t6.e0", 32'(last_a), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
